// File: rtl/dstm_ep_pkg.sv
// Shared constants and IN-packet state encodings for the DSTM FX2 endpoint model.
package dstm_ep_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] FIFOADR_OUT = 2'b00;
  localparam logic [1:0] FIFOADR_IN  = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_COMMIT  = 2'd2
  } in_state_e;

endpackage

// File: rtl/dstm_fx2_endpoint_if.sv
// Slave-FIFO bus between the FPGA stream master and the USB controller endpoint.
interface dstm_fx2_endpoint_if;

  logic       SLRD;
  logic       SLWR;
  logic       SLOE;
  logic       PKTEND;
  logic [1:0] FIFOADR;
  logic       FLAGA;
  logic       FLAGB;
  logic [7:0] FD_I;
  logic [7:0] FD_O;
  logic [7:0] FD_T;

  modport master (
    output SLRD, SLWR, SLOE, PKTEND, FIFOADR, FD_I,
    input  FLAGA, FLAGB, FD_O, FD_T
  );

  modport slave (
    input  SLRD, SLWR, SLOE, PKTEND, FIFOADR, FD_I,
    output FLAGA, FLAGB, FD_O, FD_T
  );

endinterface

// File: rtl/dstm_ep_fifo.sv
// Single-clock first-word-fall-through byte FIFO. When GATED is set, reads are
// limited to entries below lim_nxt_i (the next-cycle committed pointer).
module dstm_ep_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter bit          GATED      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_i,
  input  logic [7:0]          wr_data_i,
  input  logic                rd_i,
  input  logic [DEPTH_LOG2:0] lim_nxt_i,
  output logic [7:0]          rd_data_o,
  output logic                avail_o,
  output logic                full_o
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, lim_d;
  logic          wr_ok, rd_ok, avail_q, full_q;

  // Accept strobes only against registered flags; compute next pointers.
  always_comb begin
    wr_ok = wr_i && !full_q;
    rd_ok = rd_i && avail_q;
    wr_d  = wr_q + PW'(wr_ok);
    rd_d  = rd_q + PW'(rd_ok);
    lim_d = GATED ? lim_nxt_i : wr_d;
  end

  // Pointers and flags; flags reflect occupancy after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      avail_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      avail_q <= (lim_d != rd_d);
      full_q  <= ((wr_d - rd_d) == DEPTH_P);
    end
  end

  // Storage array, no reset needed since reads are gated by avail.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

  assign rd_data_o = avail_q ? mem[rd_q[DEPTH_LOG2-1:0]] : 8'h00;
  assign avail_o   = avail_q;
  assign full_o    = full_q;

endmodule

// File: rtl/dstm_fx2_endpoint.sv
// USB-controller side of the DSTM synchronous slave-FIFO interface: OUT FIFO
// (host->FPGA), IN FIFO (FPGA->host) with packet commit and a host byte port.
// Optional protocol checker enabled by defining DSTM_EP_PROTO_CHECK_EN.
module dstm_fx2_endpoint
  import dstm_ep_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned PKT_SIZE   = 512
) (
  input  logic                IFCLK,
  input  logic                Reset_n,
  dstm_fx2_endpoint_if.slave  bus,
  input  logic [DATA_W-1:0]   Out_Data,
  input  logic                Out_Wr,
  output logic                Out_Full,
  output logic [DATA_W-1:0]   In_Data,
  output logic                In_Valid,
  input  logic                In_Rd,
  output logic                Pkt_Commit,
  output logic [15:0]         Pkt_Count,
  output logic                Proto_Err
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PKT_LEN = PW'(PKT_SIZE);

  logic          sel_out, sel_in, out_pop, in_wr, in_push, pkt_end;
  logic          out_avail, in_full;
  logic [7:0]    out_head;
  logic [PW-1:0] u_q, u_d, u_inc, cptr_q, cptr_d;
  in_state_e     state_q, state_d;
  logic          commit_d, pkt_commit_q;
  logic [15:0]   pkt_count_q;

  assign sel_out = (bus.FIFOADR == FIFOADR_OUT);
  assign sel_in  = (bus.FIFOADR == FIFOADR_IN);
  assign out_pop = !bus.SLRD && sel_out;
  assign in_wr   = !bus.SLWR && sel_in;
  assign in_push = in_wr && !in_full;
  assign pkt_end = !bus.PKTEND && sel_in;

  assign bus.FLAGA = !out_avail;
  assign bus.FLAGB = in_full;
  assign bus.FD_O  = out_head;
  assign bus.FD_T  = (!bus.SLOE && sel_out) ? 8'h00 : 8'hFF;

  dstm_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .GATED(1'b0)) u_out_fifo (
    .clk       (IFCLK),
    .rst_n     (Reset_n),
    .wr_i      (Out_Wr),
    .wr_data_i (Out_Data),
    .rd_i      (out_pop),
    .lim_nxt_i ('0),
    .rd_data_o (out_head),
    .avail_o   (out_avail),
    .full_o    (Out_Full)
  );

  dstm_ep_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .GATED(1'b1)) u_in_fifo (
    .clk       (IFCLK),
    .rst_n     (Reset_n),
    .wr_i      (in_wr),
    .wr_data_i (bus.FD_I),
    .rd_i      (In_Rd),
    .lim_nxt_i (cptr_d),
    .rd_data_o (In_Data),
    .avail_o   (In_Valid),
    .full_o    (in_full)
  );

  // IN packet FSM: track uncommitted count and move the committed pointer.
  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    cptr_d   = cptr_q;
    commit_d = 1'b0;
    u_inc    = u_q + PW'(in_push);
    case (state_q)
      ST_FILLING: begin
        if ((u_inc == PKT_LEN) || pkt_end) commit_d = 1'b1;
        else                               state_d  = ST_FILLING;
      end
      default: begin
        if (in_push) begin
          if (u_inc == PKT_LEN) commit_d = 1'b1;
          else                  state_d  = ST_FILLING;
        end else begin
          state_d = ST_EMPTY;
        end
      end
    endcase
    if (commit_d) begin
      state_d = ST_COMMIT;
      cptr_d  = cptr_q + u_inc;
      u_d     = '0;
    end else begin
      u_d = u_inc;
    end
  end

  // FSM state, committed pointer and packet counters.
  always_ff @(posedge IFCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_EMPTY;
      u_q          <= '0;
      cptr_q       <= '0;
      pkt_commit_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      u_q          <= u_d;
      cptr_q       <= cptr_d;
      pkt_commit_q <= commit_d;
      if (commit_d) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign Pkt_Commit = pkt_commit_q;
  assign Pkt_Count  = pkt_count_q;

`ifdef DSTM_EP_PROTO_CHECK_EN
  logic proto_viol, proto_err_q;

  // Illegal master strobe combinations against the current flags.
  always_comb begin
    proto_viol = (!bus.SLRD && bus.FLAGA) ||
                 (!bus.SLWR && bus.FLAGB) ||
                 (!bus.SLRD && !bus.SLWR) ||
                 (!bus.SLOE && !sel_out)  ||
                 (!sel_out && !sel_in &&
                  (!bus.SLRD || !bus.SLWR || !bus.SLOE || !bus.PKTEND));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge IFCLK or negedge Reset_n) begin
    if (!Reset_n) proto_err_q <= 1'b0;
    else          proto_err_q <= proto_err_q | proto_viol;
  end

  assign Proto_Err = proto_err_q;
`else
  assign Proto_Err = 1'b0;
`endif

endmodule

// File: tb/tb_dstm_fx2_endpoint.sv
// Scoreboard bench for dstm_fx2_endpoint: default-size instance plus a 16-byte instance.
module tb_dstm_fx2_endpoint;

`ifdef DSTM_EP_PROTO_CHECK_EN
  localparam logic [31:0] EXP_PERR = 32'd1;
`else
  localparam logic [31:0] EXP_PERR = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance
  dstm_fx2_endpoint_if bus ();
  logic [7:0]  Out_Data, In_Data;
  logic        Out_Wr, Out_Full, In_Valid, In_Rd, Pkt_Commit, Proto_Err;
  logic [15:0] Pkt_Count;

  dstm_fx2_endpoint #(.DEPTH_LOG2(9), .PKT_SIZE(512)) dut (
    .IFCLK(clk), .Reset_n(rst_n), .bus(bus),
    .Out_Data(Out_Data), .Out_Wr(Out_Wr), .Out_Full(Out_Full),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Rd(In_Rd),
    .Pkt_Commit(Pkt_Commit), .Pkt_Count(Pkt_Count), .Proto_Err(Proto_Err)
  );

  // small instance
  dstm_fx2_endpoint_if bus_s ();
  logic [7:0]  Out_Data_s, In_Data_s;
  logic        Out_Wr_s, Out_Full_s, In_Valid_s, In_Rd_s, Pkt_Commit_s, Proto_Err_s;
  logic [15:0] Pkt_Count_s;

  dstm_fx2_endpoint #(.DEPTH_LOG2(4), .PKT_SIZE(16)) dut_s (
    .IFCLK(clk), .Reset_n(rst_n), .bus(bus_s),
    .Out_Data(Out_Data_s), .Out_Wr(Out_Wr_s), .Out_Full(Out_Full_s),
    .In_Data(In_Data_s), .In_Valid(In_Valid_s), .In_Rd(In_Rd_s),
    .Pkt_Commit(Pkt_Commit_s), .Pkt_Count(Pkt_Count_s), .Proto_Err(Proto_Err_s)
  );

  logic [7:0]  exp_out[$];
  logic [7:0]  exp_in[$];
  logic [15:0] exp_cnt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (In_Valid && n < bound) begin
      In_Rd = 1'b1;
      tick();
      n++;
    end
    In_Rd = 1'b0;
    chk("in_drained_valid", 32'(In_Valid), 32'd0);
    chk("in_drained_queue", 32'(exp_in.size()), 32'd0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard when presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.SLRD && bus.FIFOADR == 2'b00 && !bus.FLAGA) begin
        chk("fd_o_pending", 32'(exp_out.size() > 0), 32'd1);
        if (exp_out.size() > 0) chk("fd_o", 32'(bus.FD_O), 32'(exp_out.pop_front()));
      end
      if (In_Rd && In_Valid) begin
        chk("in_data_pending", 32'(exp_in.size() > 0), 32'd1);
        if (exp_in.size() > 0) chk("in_data", 32'(In_Data), 32'(exp_in.pop_front()));
      end
      if (Pkt_Commit) begin
        chk("commit_pending", 32'(exp_cnt.size() > 0), 32'd1);
        if (exp_cnt.size() > 0) chk("pkt_count", 32'(Pkt_Count), 32'(exp_cnt.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SLRD = 1'b1; bus.SLWR = 1'b1; bus.SLOE = 1'b1; bus.PKTEND = 1'b1;
    bus.FIFOADR = 2'b00; bus.FD_I = 8'h00;
    Out_Data = 8'h00; Out_Wr = 1'b0; In_Rd = 1'b0;
    bus_s.SLRD = 1'b1; bus_s.SLWR = 1'b1; bus_s.SLOE = 1'b1; bus_s.PKTEND = 1'b1;
    bus_s.FIFOADR = 2'b00; bus_s.FD_I = 8'h00;
    Out_Data_s = 8'h00; Out_Wr_s = 1'b0; In_Rd_s = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();

    // reset values
    chk("rst_flaga",      32'(bus.FLAGA),  32'd1);
    chk("rst_flagb",      32'(bus.FLAGB),  32'd0);
    chk("rst_fd_t",       32'(bus.FD_T),   32'hFF);
    chk("rst_fd_o",       32'(bus.FD_O),   32'h00);
    chk("rst_out_full",   32'(Out_Full),   32'd0);
    chk("rst_in_valid",   32'(In_Valid),   32'd0);
    chk("rst_pkt_commit", 32'(Pkt_Commit), 32'd0);
    chk("rst_pkt_count",  32'(Pkt_Count),  32'd0);
    chk("rst_proto_err",  32'(Proto_Err),  32'd0);
    #3 rst_n = 1'b1;
    tick();

    // 1: OUT FIFO load and pop
    begin
      logic [7:0] ld [4];
      ld = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
        Out_Wr = 1'b1; Out_Data = ld[i]; exp_out.push_back(ld[i]);
        tick();
      end
      Out_Wr = 1'b0;
    end
    bus.SLOE = 1'b0;
    #1;
    chk("t1_fd_t_drive", 32'(bus.FD_T), 32'h00);
    chk("t1_flaga_loaded", 32'(bus.FLAGA), 32'd0);
    for (int i = 0; i < 20 && !bus.FLAGA; i++) begin
      bus.SLRD = 1'b0;
      tick();
    end
    bus.SLRD = 1'b1;
    chk("t1_flaga_empty", 32'(bus.FLAGA), 32'd1);
    chk("t1_out_queue", 32'(exp_out.size()), 32'd0);
    bus.SLOE = 1'b1;
    #1;
    chk("t1_fd_t_tristate", 32'(bus.FD_T), 32'hFF);

    // 2: short IN packet with PKTEND
    bus.FIFOADR = 2'b10;
    begin
      logic [7:0] pk [3];
      pk = '{8'hA1, 8'hA2, 8'hA3};
      for (int i = 0; i < 3; i++) begin
        bus.SLWR = 1'b0; bus.FD_I = pk[i]; exp_in.push_back(pk[i]);
        tick();
      end
    end
    bus.SLWR = 1'b1;
    chk("t2_uncommitted_hidden", 32'(In_Valid), 32'd0);
    bus.PKTEND = 1'b0; exp_cnt.push_back(16'd1);
    tick();
    bus.PKTEND = 1'b1;
    chk("t2_pkt_commit", 32'(Pkt_Commit), 32'd1);
    chk("t2_pkt_count",  32'(Pkt_Count),  32'd1);
    chk("t2_in_valid",   32'(In_Valid),   32'd1);
    tick();
    chk("t2_commit_pulse_end", 32'(Pkt_Commit), 32'd0);
    drain(10);

    // 3: full-size auto-commit
    do_reset();
    bus.FIFOADR = 2'b10;
    for (int i = 0; i < 512; i++) begin
      bus.SLWR = 1'b0; bus.FD_I = 8'(i); exp_in.push_back(8'(i));
      if (i == 511) exp_cnt.push_back(16'd1);
      tick();
      if (i == 510) begin
        chk("t3_in_valid_511", 32'(In_Valid), 32'd0);
        chk("t3_flagb_511",    32'(bus.FLAGB), 32'd0);
      end
    end
    bus.SLWR = 1'b1;
    chk("t3_pkt_commit", 32'(Pkt_Commit), 32'd1);
    chk("t3_pkt_count",  32'(Pkt_Count),  32'd1);
    chk("t3_flagb_full", 32'(bus.FLAGB),  32'd1);
    drain(600);
    chk("t3_flagb_drained", 32'(bus.FLAGB), 32'd0);

    // 4: small instance, 17th byte dropped
    bus_s.FIFOADR = 2'b10;
    for (int i = 0; i < 17; i++) begin
      bus_s.SLWR = 1'b0; bus_s.FD_I = 8'(8'h40 + i);
      tick();
      if (i == 14) chk("t4_flagb_15", 32'(bus_s.FLAGB), 32'd0);
      if (i == 15) begin
        chk("t4_flagb_16", 32'(bus_s.FLAGB), 32'd1);
        chk("t4_pkt_count", 32'(Pkt_Count_s), 32'd1);
      end
    end
    bus_s.SLWR = 1'b1;
    chk("t4_flagb_held", 32'(bus_s.FLAGB), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_in_valid", 32'(In_Valid_s), 32'd1);
      chk("t4_in_data", 32'(In_Data_s), 32'(8'h40 + i));
      In_Rd_s = 1'b1;
      tick();
      In_Rd_s = 1'b0;
      if (i == 0) chk("t4_flagb_after_pop", 32'(bus_s.FLAGB), 32'd0);
    end
    chk("t4_drained", 32'(In_Valid_s), 32'd0);
    bus_s.PKTEND = 1'b0;
    tick();
    bus_s.PKTEND = 1'b1;
    tick();
    chk("t4_no_stray_commit", 32'(Pkt_Count_s), 32'd1);
    chk("t4_no_stray_data", 32'(In_Valid_s), 32'd0);

    // 6: reset mid-packet discards everything
    bus.FIFOADR = 2'b00;
    Out_Wr = 1'b1; Out_Data = 8'h5A;
    tick(); tick();
    Out_Wr = 1'b0;
    bus.FIFOADR = 2'b10;
    for (int i = 0; i < 5; i++) begin
      bus.SLWR = 1'b0; bus.FD_I = 8'(8'hC0 + i);
      tick();
    end
    bus.SLWR = 1'b1;
    chk("t6_flaga_before", 32'(bus.FLAGA), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_flaga",     32'(bus.FLAGA),  32'd1);
    chk("t6_rst_flagb",     32'(bus.FLAGB),  32'd0);
    chk("t6_rst_fd_o",      32'(bus.FD_O),   32'h00);
    chk("t6_rst_in_valid",  32'(In_Valid),   32'd0);
    chk("t6_rst_pkt_count", 32'(Pkt_Count),  32'd0);
    chk("t6_rst_commit",    32'(Pkt_Commit), 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("t6_in_valid_after", 32'(In_Valid), 32'd0);
    bus.PKTEND = 1'b0;
    tick();
    bus.PKTEND = 1'b1;
    tick();
    chk("t6_pktend_empty_count", 32'(Pkt_Count), 32'd0);
    chk("t6_pktend_empty_valid", 32'(In_Valid),  32'd0);

    // 7: push and PKTEND on the same edge
    bus.SLWR = 1'b0; bus.FD_I = 8'hB1; exp_in.push_back(8'hB1);
    tick();
    bus.FD_I = 8'hB2; bus.PKTEND = 1'b0; exp_in.push_back(8'hB2); exp_cnt.push_back(16'd1);
    tick();
    bus.SLWR = 1'b1; bus.PKTEND = 1'b1;
    chk("t7_pkt_commit", 32'(Pkt_Commit), 32'd1);
    tick();
    drain(10);

    // 5: protocol error on read while empty
    bus.FIFOADR = 2'b00;
    tick();
    chk("t5_proto_clean", 32'(Proto_Err), 32'd0);
    chk("t5_flaga_empty", 32'(bus.FLAGA), 32'd1);
    bus.SLRD = 1'b0;
    tick();
    bus.SLRD = 1'b1;
    chk("t5_proto_set", 32'(Proto_Err), EXP_PERR);
    chk("t5_flaga_still", 32'(bus.FLAGA), 32'd1);
    repeat (3) tick();
    chk("t5_proto_sticky", 32'(Proto_Err), EXP_PERR);
    do_reset();
    chk("t5_proto_cleared", 32'(Proto_Err), 32'd0);

    chk("end_out_queue", 32'(exp_out.size()), 32'd0);
    chk("end_in_queue",  32'(exp_in.size()),  32'd0);
    chk("end_cnt_queue", 32'(exp_cnt.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
